// File: rtl/mem_responder_rtl.sv
// Single-cycle memory responder with a one-entry response buffer.
// Requests are val/rdy handshaked; responses are {type, data} from a register.
module mem_responder_rtl #(
  parameter int p_nbits    = 8,
  parameter int p_nentries = 16,
  localparam int AW        = $clog2(p_nentries)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic               req_type,
  input  logic [AW-1:0]      req_addr,
  input  logic [p_nbits-1:0] req_data,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic               resp_type,
  output logic [p_nbits-1:0] resp_data
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 type_q, type_d;
  logic [p_nbits-1:0]   data_q, data_d;
  logic [p_nbits-1:0]   mem_q [p_nentries];
  logic [p_nbits-1:0]   mem_d [p_nentries];
  logic                 req_go;
  logic                 resp_go;

  // rst gates rdy so nothing is taken while reset is held
  assign resp_val  = (state_q == FULL);
  assign req_rdy   = rst & ((state_q == EMPTY) | resp_rdy);
  assign resp_type = type_q;
  assign resp_data = data_q;
  assign req_go    = req_val & req_rdy;
  assign resp_go   = resp_val & resp_rdy;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    data_d  = data_q;
    mem_d   = mem_q;
    if (req_go) begin
      state_d = FULL;
      type_d  = req_type;
      if (req_type) begin
        data_d           = '0;
        mem_d[req_addr]  = req_data;
      end else begin
        data_d = mem_q[req_addr];
      end
    end else if (resp_go) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      type_q  <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < p_nentries; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      data_q  <= data_d;
      for (int i = 0; i < p_nentries; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder_rtl.sv
// Scoreboard bench for mem_responder_rtl: default build plus a 1-bit x 2-entry build.
// Expected responses are queued on accepted requests and checked on drained responses.
module tb_mem_responder_rtl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_val, req_rdy, req_type;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic       resp_val, resp_rdy, resp_type;
  logic [7:0] resp_data;

  logic s_req_val, s_req_rdy, s_req_type;
  logic s_req_addr, s_req_data;
  logic s_resp_val, s_resp_rdy, s_resp_type, s_resp_data;

  typedef struct {
    logic       t;
    logic [7:0] d;
  } rsp_t;

  rsp_t       q[$];
  rsp_t       sq[$];
  logic [7:0] mem_m [16];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mem_responder_rtl dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_type(req_type), .req_addr(req_addr),
    .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_type(resp_type), .resp_data(resp_data)
  );

  mem_responder_rtl #(.p_nbits(1), .p_nentries(2)) dut_s (
    .clk(clk), .rst(rst),
    .req_val(s_req_val), .req_rdy(s_req_rdy),
    .req_type(s_req_type), .req_addr(s_req_addr),
    .req_data(s_req_data),
    .resp_val(s_resp_val), .resp_rdy(s_resp_rdy),
    .resp_type(s_resp_type), .resp_data(s_resp_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic t,
                     input logic [3:0] a, input logic [7:0] d);
    req_val  = v;
    req_type = t;
    req_addr = a;
    req_data = d;
  endtask

  function automatic logic [7:0] val(input int i);
    return 8'(i * 17 + 3);
  endfunction

  // Monitor for the default build: drain first, then queue new work
  always @(negedge clk) begin : mon
    rsp_t e;
    if (rst) begin
      if (resp_val && resp_rdy) begin
        if (q.size() == 0) begin
          chk("spurious_resp", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          chk("resp_type", 32'(resp_type), 32'(e.t));
          chk("resp_data", 32'(resp_data), 32'(e.d));
        end
      end
      if (req_val && req_rdy) begin
        e.t = req_type;
        e.d = req_type ? 8'h00 : mem_m[req_addr];
        if (req_type) mem_m[req_addr] = req_data;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : mon_s
    rsp_t e;
    if (rst && s_resp_val && s_resp_rdy) begin
      if (sq.size() == 0) begin
        chk("s_spurious", 32'(1), 32'(0));
      end else begin
        e = sq.pop_front();
        chk("s_type", 32'(s_resp_type), 32'(e.t));
        chk("s_data", 32'(s_resp_data), 32'(e.d));
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    rst        = 1'b0;
    resp_rdy   = 1'b1;
    req(1'b0, 1'b0, 4'd0, 8'd0);
    s_req_val  = 1'b0;
    s_req_type = 1'b0;
    s_req_addr = 1'b0;
    s_req_data = 1'b0;
    s_resp_rdy = 1'b1;

    #2;
    chk("rst_resp_val", 32'(resp_val), 32'(0));
    chk("rst_resp_type", 32'(resp_type), 32'(0));
    chk("rst_resp_data", 32'(resp_data), 32'(0));
    chk("rst_req_rdy", 32'(req_rdy), 32'(0));
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(req_rdy), 32'(1));

    // read of never-written address
    req(1'b1, 1'b0, 4'd3, 8'h00);
    tick();
    chk("rd3_val", 32'(resp_val), 32'(1));
    // write then read-after-write
    req(1'b1, 1'b1, 4'd5, 8'hA5);
    tick();
    req(1'b1, 1'b0, 4'd5, 8'h00);
    tick();
    req(1'b0, 1'b0, 4'd0, 8'h00);
    tick();

    for (int i = 0; i < 16; i++) begin
      req(1'b1, 1'b1, 4'(i), val(i));
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 1'b0, 4'(i), 8'h00);
      #2;
      chk("b2b_rdy", 32'(req_rdy), 32'(1));
      chk("b2b_val", 32'(resp_val), 32'(1));
      @(posedge clk);
      #1;
    end

    // stall while FULL with a pending read
    resp_rdy = 1'b0;
    req(1'b1, 1'b0, 4'd2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_rdy", 32'(req_rdy), 32'(0));
      chk("stall_val", 32'(resp_val), 32'(1));
      chk("stall_data", 32'(resp_data), 32'(val(15)));
      @(posedge clk);
      #1;
    end
    resp_rdy = 1'b1;
    #1;
    chk("unstall_rdy", 32'(req_rdy), 32'(1));
    @(posedge clk);
    #1;
    req(1'b0, 1'b0, 4'd0, 8'h00);
    chk("unstall_val", 32'(resp_val), 32'(1));
    chk("unstall_data", 32'(resp_data), 32'(val(2)));
    tick();
    chk("idle_val", 32'(resp_val), 32'(0));

    // reset while FULL drops the response at once and clears memory
    resp_rdy = 1'b0;
    req(1'b1, 1'b1, 4'd7, 8'h3C);
    tick();
    req(1'b0, 1'b0, 4'd0, 8'h00);
    chk("full_val", 32'(resp_val), 32'(1));
    #2;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    #1;
    chk("async_val", 32'(resp_val), 32'(0));
    chk("async_rdy", 32'(req_rdy), 32'(0));
    tick();
    rst      = 1'b1;
    resp_rdy = 1'b1;
    req(1'b1, 1'b0, 4'd7, 8'h00);
    tick();
    req(1'b0, 1'b0, 4'd0, 8'h00);
    chk("rd7_val", 32'(resp_val), 32'(1));
    chk("rd7_data", 32'(resp_data), 32'(0));
    tick();

    // narrow build: write 1 to addr 1, read 0 then 1
    s_req_val  = 1'b1;
    s_req_type = 1'b1;
    s_req_addr = 1'b1;
    s_req_data = 1'b1;
    sq.push_back('{t: 1'b1, d: 8'h00});
    tick();
    s_req_type = 1'b0;
    s_req_addr = 1'b0;
    s_req_data = 1'b0;
    sq.push_back('{t: 1'b0, d: 8'h00});
    tick();
    s_req_addr = 1'b1;
    sq.push_back('{t: 1'b0, d: 8'h01});
    tick();
    s_req_val = 1'b0;
    chk("s_last_data", 32'(s_resp_data), 32'(1));
    repeat (2) tick();

    chk("q_empty", 32'(q.size()), 32'(0));
    chk("sq_empty", 32'(sq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
